multi_cycle_controller: RTL and testbench

Multi-cycle control FSM for the RV32I core variant with a single shared memory port and one shared ALU. Each cycle it sequences the datapath through fetch, decode, execute, memory and writeback. It drives register, memory, PC and mux enables, handles a ready/req memory handshake with variable latency, resolves branches from the ALU flags, and counts retired instructions.

---
 rtl/multi_cycle_controller_if.sv | 11 +
 rtl/multi_cycle_controller.sv | 206 ++++++++++++++++++++
 tb/tb_multi_cycle_controller.sv | 325 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/multi_cycle_controller_if.sv
// Shared-memory handshake between the multi-cycle controller and the memory port.
// The controller drives the request side. The memory answers with mem_ready.
interface multi_cycle_controller_if;
    logic mem_req;
    logic mem_write;
    logic adr_src;
    logic mem_ready;

    modport master (output mem_req, output mem_write, output adr_src, input mem_ready);
    modport slave  (input mem_req, input mem_write, input adr_src, output mem_ready);
endinterface

// File: rtl/multi_cycle_controller.sv
// Multi-cycle RV32I control FSM: sequences fetch/decode/execute/memory/writeback over
// one shared memory port and one ALU, and counts retired instructions.
module multi_cycle_controller #(
    parameter int CNT_W = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    multi_cycle_controller_if.master mem,
    input  logic [6:0]               op,
    input  logic [2:0]               funct3,
    input  logic                     zero,
    input  logic                     b31,
    output logic                     ir_write,
    output logic                     pc_write,
    output logic                     reg_write,
    output logic [1:0]               alu_src_a,
    output logic [1:0]               alu_src_b,
    output logic [1:0]               alu_op,
    output logic [1:0]               result_src,
    output logic [2:0]               imm_src,
    output logic                     illegal,
    output logic                     retire,
    output logic [CNT_W-1:0]         instret
);

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_S    = 7'b0100011;
    localparam logic [6:0] OP_B    = 7'b1100011;
    localparam logic [6:0] OP_LUI  = 7'b0110111;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_JALR = 7'b1100111;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEM_ADR, S_MEM_READ, S_MEM_WB, S_MEM_WRITE,
        S_EXEC_R, S_EXEC_I, S_ALU_WB, S_BRANCH, S_JAL, S_JALR_ADR,
        S_JALR_JMP, S_LUI_WB, S_TRAP
    } state_t;

    state_t state;
    state_t state_next;
    logic   taken;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_FETCH;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instret <= '0;
        end else if (retire) begin
            instret <= instret + CNT_W'(1);
        end
    end

    always_comb begin
        taken = 1'b0;
        case (funct3)
            3'b000:  taken = zero;
            3'b001:  taken = !zero;
            3'b100:  taken = b31;
            3'b101:  taken = !b31;
            default: taken = 1'b0;
        endcase
    end

    // NOTE: every output gets a default first so no path through the case can infer a latch.
    always_comb begin
        state_next    = state;
        mem.mem_req   = 1'b0;
        mem.mem_write = 1'b0;
        mem.adr_src   = 1'b0;
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 2'b00;
        alu_src_b     = 2'b00;
        alu_op        = 2'b00;
        result_src    = 2'b00;
        illegal       = 1'b0;

        case (state)
            S_FETCH: begin
                mem.mem_req = 1'b1;
                if (mem.mem_ready) begin
                    ir_write   = 1'b1;
                    pc_write   = 1'b1;
                    alu_src_b  = 2'b10;
                    result_src = 2'b10;
                    state_next = S_DECODE;
                end
            end
            S_DECODE: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                case (op)
                    OP_LW, OP_S: state_next = S_MEM_ADR;
                    OP_R:        state_next = S_EXEC_R;
                    OP_I:        state_next = S_EXEC_I;
                    OP_B:        state_next = S_BRANCH;
                    OP_JAL:      state_next = S_JAL;
                    OP_JALR:     state_next = S_JALR_ADR;
                    OP_LUI:      state_next = S_LUI_WB;
                    default:     state_next = S_TRAP;
                endcase
            end
            S_MEM_ADR: begin
                alu_src_a  = 2'b10;
                alu_src_b  = 2'b01;
                state_next = (op == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
            end
            S_MEM_READ: begin
                mem.mem_req = 1'b1;
                mem.adr_src = 1'b1;
                if (mem.mem_ready) state_next = S_MEM_WB;
            end
            S_MEM_WB: begin
                result_src = 2'b01;
                reg_write  = 1'b1;
                state_next = S_FETCH;
            end
            S_MEM_WRITE: begin
                mem.mem_req   = 1'b1;
                mem.mem_write = 1'b1;
                mem.adr_src   = 1'b1;
                if (mem.mem_ready) state_next = S_FETCH;
            end
            S_EXEC_R: begin
                alu_src_a  = 2'b10;
                alu_op     = 2'b10;
                state_next = S_ALU_WB;
            end
            S_EXEC_I: begin
                alu_src_a  = 2'b10;
                alu_src_b  = 2'b01;
                alu_op     = 2'b11;
                state_next = S_ALU_WB;
            end
            S_ALU_WB: begin
                reg_write  = 1'b1;
                state_next = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a  = 2'b10;
                alu_op     = 2'b01;
                pc_write   = taken;
                state_next = S_FETCH;
            end
            // JAL and JALR_JMP both load the target from alu_out, then write old_pc+4 in ALU_WB.
            S_JAL, S_JALR_JMP: begin
                alu_src_a  = 2'b01;
                alu_src_b  = 2'b10;
                pc_write   = 1'b1;
                state_next = S_ALU_WB;
            end
            S_JALR_ADR: begin
                alu_src_a  = 2'b10;
                alu_src_b  = 2'b01;
                state_next = S_JALR_JMP;
            end
            S_LUI_WB: begin
                result_src = 2'b11;
                reg_write  = 1'b1;
                state_next = S_FETCH;
            end
            S_TRAP: begin
                illegal = 1'b1;
            end
            default: state_next = S_FETCH;
        endcase

        retire = (state != S_FETCH) && (state_next == S_FETCH);

        case (op)
            OP_S:    imm_src = 3'b001;
            OP_B:    imm_src = 3'b010;
            OP_JAL:  imm_src = 3'b011;
            OP_LUI:  imm_src = 3'b100;
            default: imm_src = 3'b000;
        endcase

        // Reset forces every output low even though the state register already reads FETCH.
        if (rst) begin
            mem.mem_req   = 1'b0;
            mem.mem_write = 1'b0;
            mem.adr_src   = 1'b0;
            ir_write      = 1'b0;
            pc_write      = 1'b0;
            reg_write     = 1'b0;
            alu_src_a     = 2'b00;
            alu_src_b     = 2'b00;
            alu_op        = 2'b00;
            result_src    = 2'b00;
            imm_src       = 3'b000;
            illegal       = 1'b0;
            retire        = 1'b0;
        end
    end

endmodule

// File: tb/tb_multi_cycle_controller.sv
// Bench for multi_cycle_controller: each instruction is expanded into its expected
// per-cycle control words, and one compare process checks the DUT every cycle.
module tb_multi_cycle_controller;

    localparam int CNT_W = 4;

    typedef struct packed {
        logic             mem_req;
        logic             mem_write;
        logic             adr_src;
        logic             ir_write;
        logic             pc_write;
        logic             reg_write;
        logic [1:0]       a;
        logic [1:0]       b;
        logic [1:0]       aop;
        logic [1:0]       rs;
        logic [2:0]       imm;
        logic             illegal;
        logic             retire;
        logic [CNT_W-1:0] instret;
    } ctrl_t;

    typedef enum {K_R, K_I, K_S, K_B, K_LUI, K_JAL, K_LW, K_JALR, K_BAD} kind_t;

    typedef struct {
        logic [6:0] op;
        logic [2:0] f3;
        logic       zero;
        logic       b31;
        int         fw;
        int         mw;
    } instr_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [6:0]       op = '0;
    logic [2:0]       funct3 = '0;
    logic             zero = 1'b0;
    logic             b31 = 1'b0;
    logic             ir_write, pc_write, reg_write, illegal, retire;
    logic [1:0]       alu_src_a, alu_src_b, alu_op, result_src;
    logic [2:0]       imm_src;
    logic [CNT_W-1:0] instret;

    multi_cycle_controller_if bus ();

    multi_cycle_controller #(.CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .mem        (bus),
        .op         (op),
        .funct3     (funct3),
        .zero       (zero),
        .b31        (b31),
        .ir_write   (ir_write),
        .pc_write   (pc_write),
        .reg_write  (reg_write),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .alu_op     (alu_op),
        .result_src (result_src),
        .imm_src    (imm_src),
        .illegal    (illegal),
        .retire     (retire),
        .instret    (instret)
    );

    always #5 clk = ~clk;

    int               errors = 0;
    int               checks = 0;
    int               cyc_ctr = 0;
    int               run_start = 0;
    int               rw_at = 0;
    int               req_cnt = 0;
    ctrl_t            exp_q[$];
    ctrl_t            seq[$];
    logic             rdy_seq[$];
    logic [CNT_W-1:0] model_cnt = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    function automatic ctrl_t sample();
        ctrl_t c;
        c.mem_req   = bus.mem_req;
        c.mem_write = bus.mem_write;
        c.adr_src   = bus.adr_src;
        c.ir_write  = ir_write;
        c.pc_write  = pc_write;
        c.reg_write = reg_write;
        c.a         = alu_src_a;
        c.b         = alu_src_b;
        c.aop       = alu_op;
        c.rs        = result_src;
        c.imm       = imm_src;
        c.illegal   = illegal;
        c.retire    = retire;
        c.instret   = instret;
        return c;
    endfunction

    // Single compare process: one full control-word check per cycle with an expectation queued.
    always @(negedge clk) begin
        ctrl_t e;
        cyc_ctr++;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check($sformatf("cycle%0d", cyc_ctr - run_start), 64'(sample()), 64'(e));
        end
        if (reg_write && rw_at == 0) rw_at = cyc_ctr - run_start;
        if (bus.mem_req) req_cnt++;
    end

    function automatic kind_t kind_of(input logic [6:0] o);
        case (o)
            7'b0110011: return K_R;
            7'b0010011: return K_I;
            7'b0100011: return K_S;
            7'b1100011: return K_B;
            7'b0110111: return K_LUI;
            7'b1101111: return K_JAL;
            7'b0000011: return K_LW;
            7'b1100111: return K_JALR;
            default:    return K_BAD;
        endcase
    endfunction

    function automatic logic [2:0] imm_of(input logic [6:0] o);
        case (kind_of(o))
            K_S:     return 3'b001;
            K_B:     return 3'b010;
            K_JAL:   return 3'b011;
            K_LUI:   return 3'b100;
            default: return 3'b000;
        endcase
    endfunction

    function automatic logic taken_of(input instr_t d);
        case (d.f3)
            3'b000:  return d.zero;
            3'b001:  return !d.zero;
            3'b100:  return d.b31;
            3'b101:  return !d.b31;
            default: return 1'b0;
        endcase
    endfunction

    function automatic ctrl_t blank(input logic [6:0] o);
        ctrl_t c = '0;
        c.imm     = imm_of(o);
        c.instret = model_cnt;
        return c;
    endfunction

    task automatic add(input ctrl_t c, input logic rdy, input bit ret);
        ctrl_t w = c;
        w.retire = ret;
        seq.push_back(w);
        rdy_seq.push_back(rdy);
        if (ret) model_cnt = model_cnt + 1'b1;
    endtask

    // Expands one instruction into its expected control words, cycle by cycle.
    task automatic build(input instr_t d, input int trap_n);
        ctrl_t c;
        kind_t k = kind_of(d.op);
        seq.delete();
        rdy_seq.delete();
        for (int i = 0; i < d.fw; i++) begin
            c = blank(d.op); c.mem_req = 1; add(c, 1'b0, 0);
        end
        c = blank(d.op); c.mem_req = 1; c.ir_write = 1; c.pc_write = 1;
        c.b = 2'b10; c.rs = 2'b10; add(c, 1'b1, 0);
        c = blank(d.op); c.a = 2'b01; c.b = 2'b01; add(c, 1'b1, 0);
        case (k)
            K_R:  begin c = blank(d.op); c.a = 2'b10; c.aop = 2'b10; add(c, 1'b1, 0); end
            K_I:  begin c = blank(d.op); c.a = 2'b10; c.b = 2'b01; c.aop = 2'b11; add(c, 1'b1, 0); end
            K_B:  begin
                c = blank(d.op); c.a = 2'b10; c.aop = 2'b01; c.pc_write = taken_of(d);
                add(c, 1'b1, 1);
            end
            K_LUI: begin c = blank(d.op); c.rs = 2'b11; c.reg_write = 1; add(c, 1'b1, 1); end
            K_JAL: begin c = blank(d.op); c.a = 2'b01; c.b = 2'b10; c.pc_write = 1; add(c, 1'b1, 0); end
            K_JALR: begin
                c = blank(d.op); c.a = 2'b10; c.b = 2'b01; add(c, 1'b1, 0);
                c = blank(d.op); c.a = 2'b01; c.b = 2'b10; c.pc_write = 1; add(c, 1'b1, 0);
            end
            K_LW, K_S: begin
                c = blank(d.op); c.a = 2'b10; c.b = 2'b01; add(c, 1'b1, 0);
                for (int i = 0; i <= d.mw; i++) begin
                    c = blank(d.op); c.mem_req = 1; c.adr_src = 1; c.mem_write = (k == K_S);
                    add(c, (i == d.mw), (k == K_S) && (i == d.mw));
                end
                if (k == K_LW) begin
                    c = blank(d.op); c.rs = 2'b01; c.reg_write = 1; add(c, 1'b1, 1);
                end
            end
            default: begin
                for (int i = 0; i < trap_n; i++) begin
                    c = blank(d.op); c.illegal = 1; add(c, 1'b1, 0);
                end
            end
        endcase
        if (k inside {K_R, K_I, K_JAL, K_JALR}) begin
            c = blank(d.op); c.reg_write = 1; add(c, 1'b1, 1);
        end
    endtask

    // Entered and left at posedge+1; drives one instruction for at most 'limit' cycles.
    task automatic run(input instr_t d, input int limit, input int trap_n, output int ncyc);
        build(d, trap_n);
        run_start = cyc_ctr;
        req_cnt   = 0;
        rw_at     = 0;
        ncyc      = 0;
        for (int i = 0; i < seq.size() && i < limit; i++) begin
            op            = d.op;
            funct3        = d.f3;
            zero          = d.zero;
            b31           = d.b31;
            bus.mem_ready = rdy_seq[i];
            exp_q.push_back(seq[i]);
            @(posedge clk);
            #1;
            ncyc++;
        end
    endtask

    task automatic do_reset(input string name);
        rst           = 1'b1;
        bus.mem_ready = 1'b0;
        #1;
        check(name, 64'(sample()), 64'(0));
        model_cnt = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    function automatic instr_t mk(input logic [6:0] o, input logic [2:0] f, input logic z,
                                  input logic s, input int fw, input int mw);
        instr_t d;
        d.op = o; d.f3 = f; d.zero = z; d.b31 = s; d.fw = fw; d.mw = mw;
        return d;
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bus.mem_ready = 1'b0;
        op            = 7'b0110011;
        @(negedge clk);
        do_reset("reset_outputs_zero");

        run(mk(7'b0110011, 3'b000, 0, 0, 0, 0), 99, 0, n);
        check("r_cycles", 64'(n), 64'(4));
        check("r_regwrite_cycle", 64'(rw_at), 64'(4));
        check("r_instret", 64'(instret), 64'(1));

        run(mk(7'b0000011, 3'b010, 0, 0, 3, 3), 99, 0, n);
        check("lw_regwrite_cycle", 64'(rw_at), 64'(11));
        check("lw_req_cycles", 64'(req_cnt), 64'(8));

        run(mk(7'b1100011, 3'b000, 1, 0, 0, 0), 99, 0, n);   // BEQ taken
        check("b_cycles", 64'(n), 64'(3));
        run(mk(7'b1100011, 3'b000, 0, 0, 0, 0), 99, 0, n);   // BEQ not taken
        run(mk(7'b1100011, 3'b100, 0, 1, 0, 0), 99, 0, n);   // BLT taken
        run(mk(7'b1100011, 3'b101, 0, 1, 0, 0), 99, 0, n);   // BGE not taken
        run(mk(7'b1100011, 3'b001, 0, 0, 1, 0), 99, 0, n);   // BNE taken
        run(mk(7'b1100011, 3'b010, 1, 1, 0, 0), 99, 0, n);   // undefined funct3
        run(mk(7'b0010011, 3'b000, 0, 0, 0, 0), 99, 0, n);
        run(mk(7'b0100011, 3'b010, 0, 0, 0, 2), 99, 0, n);
        run(mk(7'b1101111, 3'b000, 0, 0, 0, 0), 99, 0, n);
        run(mk(7'b0110111, 3'b000, 0, 0, 0, 0), 99, 0, n);
        check("lui_cycles", 64'(n), 64'(3));
        run(mk(7'b1100111, 3'b000, 0, 0, 0, 0), 99, 0, n);
        check("jalr_cycles", 64'(n), 64'(5));
        check("instret_after_mix", 64'(instret), 64'(13));

        run(mk(7'b1111111, 3'b000, 0, 0, 0, 0), 99, 20, n);
        check("trap_cycles", 64'(n), 64'(22));
        check("trap_req_cycles", 64'(req_cnt), 64'(1));
        check("trap_illegal", 64'(illegal), 64'(1));
        do_reset("trap_reset_outputs_zero");
        check("trap_cleared_illegal", 64'(illegal), 64'(0));
        check("trap_cleared_instret", 64'(instret), 64'(0));

        run(mk(7'b0110011, 3'b000, 0, 0, 0, 0), 99, 0, n);
        run(mk(7'b0100011, 3'b010, 0, 0, 0, 10), 5, 0, n);
        check("abort_pending_write", 64'(bus.mem_write), 64'(1));
        rst = 1'b1;
        #1;
        check("abort_write_drop", 64'(bus.mem_write), 64'(0));
        check("abort_no_retire", 64'(retire), 64'(0));
        check("abort_instret_clear", 64'(instret), 64'(0));
        model_cnt = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        run(mk(7'b0110011, 3'b000, 0, 0, 0, 0), 99, 0, n);
        check("resume_instret", 64'(instret), 64'(1));

        for (int i = 0; i < 14; i++) run(mk(7'b1100011, 3'b000, 1, 0, 0, 0), 99, 0, n);
        check("instret_all_ones", 64'(instret), 64'(4'hF));
        run(mk(7'b1100011, 3'b000, 1, 0, 0, 0), 99, 0, n);
        check("instret_wrap", 64'(instret), 64'(0));

        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
